ps2_rx_fifo: RTL
================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8; key-event FIFO entries, power of 2, range 2..64.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000; Clock_50 cycles with no PS/2 falling edge before a mid-frame abort (1 ms).
REQ-003 SHALL have parameter SYNC_STAGES, default 2; synchroniser flops on PS2_clock and PS2_data, range 2..4.
REQ-004 SHALL have port Clock_50  input  1  system clock, 50 MHz, all logic on its rising edge.
REQ-005 SHALL have port Resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port PS2_clock  input  1  raw PS/2 clock line.
REQ-007 SHALL have port PS2_data  input  1  raw PS/2 data line.
REQ-008 SHALL have port Key_pop  input  1  consumer pops the FIFO head this cycle.
REQ-009 SHALL have port Key_valid  output  1  FIFO non-empty.
REQ-010 SHALL have port Key_code  output  8  head entry scan code.
REQ-011 SHALL have port Key_extended  output  1  head entry was preceded by E0.
REQ-012 SHALL have port Key_break  output  1  head entry was preceded by F0 (key release).
REQ-013 SHALL have port Key_count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-014 SHALL have port Frame_error  output  1  one-cycle pulse on parity, stop or timeout failure.
REQ-015 SHALL have port Overflow  output  1  sticky; set when a completed event is dropped because the FIFO is full.
REQ-016 SHALL have port Error_count  output  8  saturating count of Frame_error pulses.

Function
REQ-017 SHALL pass PS2_clock and PS2_data through SYNC_STAGES flops and detect a falling edge as sync=0 with previous sync=1; the data bit is the synchronised data at that edge.
REQ-018 SHALL implement states IDLE, DATA, PARITY, STOP: IDLE->DATA on an edge with data 0; DATA shifts 8 bits LSB first, then ->PARITY; PARITY latches the bit, ->STOP; STOP validates and ->IDLE.
REQ-019 SHALL accept a frame only if the stop bit is 1 and (REQ-030) parity is odd over data+parity; otherwise discard it, pulse Frame_error, clear both prefix flags.
REQ-020 SHALL, in any non-IDLE state, count cycles since the last edge; reaching TIMEOUT_CYCLES SHALL force IDLE, pulse Frame_error, clear prefix flags; the counter SHALL reset on every edge and in IDLE.
REQ-021 SHALL treat accepted byte E0 as setting the extended flag and F0 as setting the break flag, no push; any other accepted byte SHALL push {extended, break, byte} and clear both flags in the same cycle.
REQ-022 SHALL complete a push in the cycle after the STOP-state edge; Key_valid SHALL rise on the following cycle.
REQ-023 SHALL present the head entry combinationally from FIFO storage while Key_valid=1; Key_pop with Key_valid=0 SHALL be ignored.
REQ-024 SHALL, on simultaneous push and pop when full, perform both; count unchanged, no Overflow.
REQ-025 SHALL, on push when full without pop, drop the event and set Overflow; Overflow clears only on reset.
REQ-026 SHALL saturate Error_count at 255.
REQ-027 SHALL wrap read/write pointers modulo FIFO_DEPTH.

Reset
REQ-028 SHALL, on Resetn=0, asynchronously clear state to IDLE, synchronisers to 1, shift/bit/timeout counters, prefix flags, pointers, Key_count, Key_valid, Frame_error, Overflow, Error_count to 0; Key_code, Key_extended, Key_break read 0.
REQ-029 SHALL abort any in-progress frame on reset without a Frame_error pulse.

Configuration
REQ-030 SHALL, with macro PS2_PARITY_CHECK_EN defined, enforce odd parity per REQ-019; without it, store but ignore the parity bit, with only stop-bit and timeout errors.

Verification
REQ-031 Frame 0x1C, odd parity, stop 1 -> Key_valid=1, Key_code=1C, Key_extended=0, Key_break=0, Key_count=1.
REQ-032 Frames E0, F0, 75 -> exactly one entry: 75, extended=1, break=1; Frame_error never pulses.
REQ-033 Frame 0x1C with even parity -> no push, Frame_error pulse, Error_count=1 (with PS2_PARITY_CHECK_EN); a push of 1C without it.
REQ-034 Four edges, then clock held high 50000 cycles -> return to IDLE, one Frame_error pulse; a following valid 0x2A frame is received correctly.
REQ-035 FIFO_DEPTH=8, nine events, no pops -> Key_count=8, Overflow=1, first 8 codes popped in order; push+pop together when full -> Key_count stays 8.
REQ-036 Resetn asserted after bit 4 of a frame, then released -> all outputs 0, no Frame_error; next valid frame received.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronised frame decoder with E0/F0 prefix folding into a key-event FIFO.
// Optional build macro PS2_PARITY_CHECK_EN enables odd-parity rejection of received frames.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                         Clock_50,
  input  logic                         Resetn,
  input  logic                         PS2_clock,
  input  logic                         PS2_data,
  input  logic                         Key_pop,
  output logic                         Key_valid,
  output logic [7:0]                   Key_code,
  output logic                         Key_extended,
  output logic                         Key_break,
  output logic [$clog2(FIFO_DEPTH):0]  Key_count,
  output logic                         Frame_error,
  output logic                         Overflow,
  output logic [7:0]                   Error_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_PARITY_CHECK_EN
  localparam logic PARITY_CHECK = 1'b1;
`else
  localparam logic PARITY_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [8:0]             shift_q, shift_d;
  logic [TW-1:0]          to_cnt_q, to_cnt_d;
  logic                   done_q, done_d;
  logic                   err_d;
  logic                   ext_q, brk_q;
  logic [AW-1:0]          wptr_q, rptr_q;
  logic [CW-1:0]          count_q;
  logic                   ovf_q, frame_err_q;
  logic [7:0]             err_cnt_q;
  logic [9:0]             mem_q [FIFO_DEPTH];

  logic fall, bit_in, parity_ok, is_e0, is_f0, push, pop, full, wr_en;
  logic [9:0] head;

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_clock};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_data};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign bit_in = dat_sync_q[SYNC_STAGES-1];
  // shift_q holds {parity, data[7:0]} once the parity bit has been shifted in
  assign parity_ok = (^shift_q) | ~PARITY_CHECK;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: if (fall && !bit_in) begin
        state_d   = DATA;
        bit_cnt_d = '0;
      end
      DATA: if (fall) begin
        shift_d   = {bit_in, shift_q[8:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        shift_d = {bit_in, shift_q[8:1]};
        state_d = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if (bit_in && parity_ok) done_d = 1'b1;
        else                     err_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !fall) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      done_q      <= done_d;
      frame_err_q <= err_d;
      if (err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // the accepted byte stays in shift_q during the push cycle; IDLE never shifts
  assign is_e0 = shift_q[7:0] == 8'hE0;
  assign is_f0 = shift_q[7:0] == 8'hF0;
  assign push  = done_q & ~is_e0 & ~is_f0;
  assign pop   = Key_pop & Key_valid;
  assign full  = count_q == CW'(FIFO_DEPTH);
  assign wr_en = push & (~full | pop);

  always_ff @(posedge Clock_50 or negedge Resetn) begin
    if (!Resetn) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (err_d) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (done_q) begin
        if (is_e0)      ext_q <= 1'b1;
        else if (is_f0) brk_q <= 1'b1;
        else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      end
      if (wr_en) wptr_q <= wptr_q + AW'(1);
      if (pop)   rptr_q <= rptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge Clock_50) begin
    if (wr_en) mem_q[wptr_q] <= {ext_q, brk_q, shift_q[7:0]};
  end

  assign head         = mem_q[rptr_q];
  assign Key_valid    = count_q != '0;
  assign Key_code     = Key_valid ? head[7:0] : '0;
  assign Key_break    = Key_valid & head[8];
  assign Key_extended = Key_valid & head[9];
  assign Key_count    = count_q;
  assign Frame_error  = frame_err_q;
  assign Overflow     = ovf_q;
  assign Error_count  = err_cnt_q;

endmodule
